led_scan_drv: RTL and testbench

Time-multiplexed LED matrix driver placed directly downstream of the game core. It takes the core's flat 18-bit LED-on vector and drives a row/column matrix: 3 active-low row commons × 6 active-high column lines. Each frame is latched in one snapshot so the display never tears. An inter-row blanking gap suppresses ghosting, and optional 16-step PWM dimming is available.

---
 rtl/led_scan_pkg.sv | 26 ++
 rtl/led_scan_tmr.sv | 60 ++++++
 rtl/led_scan_drv.sv | 123 ++++++++++++
 tb/tb_led_scan_drv.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/led_scan_pkg.sv
// Shared types and constants for the LED matrix scan driver.
// The optional dimming feature is enabled by defining LED_SCAN_PWM_EN.
package led_scan_pkg;

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_DRIVE = 1'b1
    } phase_e;

    localparam int unsigned PWM_STEP_N = 16;
    localparam int unsigned DIM_W      = 4;
    localparam logic [DIM_W-1:0] DIM_RST = 4'd15;

    // Bits needed to hold the values 0..n-1 (never less than one bit).
    function automatic int unsigned width_of(input int unsigned n);
        int unsigned w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/led_scan_tmr.sv
// Row/period counter pair for the LED scan driver. Publishes the values the
// counters take on the next edge plus the frame-start condition.
module led_scan_tmr
    import led_scan_pkg::*;
#(
    parameter int unsigned C_ROW_N    = 3,
    parameter int unsigned C_ROW_CK_N = 135_000,
    localparam int unsigned RW = width_of(C_ROW_N),
    localparam int unsigned CW = width_of(C_ROW_CK_N)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [RW-1:0] row_nxt,
    output logic [CW-1:0] ctr_nxt,
    output logic          frame_start
);

    localparam logic [RW-1:0] ROW_LAST = RW'(C_ROW_N - 1);
    localparam logic [CW-1:0] CTR_LAST = CW'(C_ROW_CK_N - 1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);
    localparam logic [CW-1:0] CTR_ONE  = CW'(1);

    logic [RW-1:0] row_r;
    logic [CW-1:0] ctr_r;
    logic [RW-1:0] row_nxt_s;
    logic [CW-1:0] ctr_nxt_s;

    // Next-count decode: period counter wraps into the following row.
    always_comb begin
        ctr_nxt_s = ctr_r;
        row_nxt_s = row_r;
        if (ctr_r == CTR_LAST) begin
            ctr_nxt_s = '0;
            if (row_r == ROW_LAST) begin
                row_nxt_s = '0;
            end else begin
                row_nxt_s = row_r + ROW_ONE;
            end
        end else begin
            ctr_nxt_s = ctr_r + CTR_ONE;
            row_nxt_s = row_r;
        end
    end

    // Counter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_r <= '0;
            ctr_r <= '0;
        end else begin
            row_r <= row_nxt_s;
            ctr_r <= ctr_nxt_s;
        end
    end

    assign row_nxt     = row_nxt_s;
    assign ctr_nxt     = ctr_nxt_s;
    assign frame_start = (ctr_r == '0) && (row_r == '0);

endmodule

// File: rtl/led_scan_drv.sv
// Time-multiplexed LED matrix driver: per-frame snapshot, inter-row blanking,
// registered row/column drives. Define LED_SCAN_PWM_EN for 16-step dimming.
module led_scan_drv
    import led_scan_pkg::*;
#(
    parameter int unsigned C_F_CK     = 135_000_000,
    parameter int unsigned C_ROW_N    = 3,
    parameter int unsigned C_COL_N    = 6,
    parameter int unsigned C_ROW_CK_N = 135_000,
    parameter int unsigned C_BLANK_N  = 1_350
) (
    input  logic                       CK_i,
    input  logic                       XARST_i,
    input  logic [C_ROW_N*C_COL_N-1:0] LEDs_ON_i,
`ifdef LED_SCAN_PWM_EN
    input  logic [DIM_W-1:0]           DIM_i,
`endif
    output logic [C_ROW_N-1:0]         ROW_XEN_o,
    output logic [C_COL_N-1:0]         COLs_o,
    output logic                       FRAME_o
);

    localparam int unsigned RW = width_of(C_ROW_N);
    localparam int unsigned CW = width_of(C_ROW_CK_N);
    localparam int unsigned SW = width_of(C_ROW_N * C_COL_N);

    if (C_F_CK == 0 || C_BLANK_N < 1 || C_BLANK_N >= C_ROW_CK_N) begin : g_bad_cfg
        $error("led_scan_drv: need 1 <= C_BLANK_N < C_ROW_CK_N");
    end

    logic [RW-1:0]                row_nxt_s;
    logic [CW-1:0]                ctr_nxt_s;
    logic                         frame_start_s;
    logic [C_ROW_N*C_COL_N-1:0]   snap_r;
    logic [SW-1:0]                base_s;
    logic                         col_en_s;
    phase_e                       phase_s;
    logic [C_ROW_N-1:0]           row_xen_nxt_s;
    logic [C_COL_N-1:0]           cols_nxt_s;

    led_scan_tmr #(
        .C_ROW_N    (C_ROW_N),
        .C_ROW_CK_N (C_ROW_CK_N)
    ) u_tmr (
        .clk         (CK_i),
        .rst_n       (XARST_i),
        .row_nxt     (row_nxt_s),
        .ctr_nxt     (ctr_nxt_s),
        .frame_start (frame_start_s)
    );

`ifdef LED_SCAN_PWM_EN
    localparam int unsigned STEP_CK_N = (C_ROW_CK_N - C_BLANK_N) / PWM_STEP_N;

    if (((C_ROW_CK_N - C_BLANK_N) % PWM_STEP_N) != 0) begin : g_bad_pwm
        $error("led_scan_drv: drive window must split into 16 equal steps");
    end

    logic [DIM_W-1:0] dim_r;
    logic [CW-1:0]    step_s;

    // Dimming gate: columns stay lit only for steps 0..dim_r of the window.
    always_comb begin
        step_s   = (ctr_nxt_s - CW'(C_BLANK_N)) / CW'(STEP_CK_N);
        col_en_s = (step_s <= CW'(dim_r));
    end

    // Brightness is captured together with the frame snapshot.
    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            dim_r <= DIM_RST;
        end else if (frame_start_s) begin
            dim_r <= DIM_i;
        end
    end
`else
    assign col_en_s = 1'b1;
`endif

    // Output decode from the counter values that take effect on the next edge.
    always_comb begin
        row_xen_nxt_s = '1;
        cols_nxt_s    = '0;
        base_s        = SW'(row_nxt_s) * SW'(C_COL_N);
        if (ctr_nxt_s < CW'(C_BLANK_N)) begin
            phase_s = PH_BLANK;
        end else begin
            phase_s = PH_DRIVE;
        end
        case (phase_s)
            PH_DRIVE: begin
                row_xen_nxt_s[row_nxt_s] = 1'b0;
                if (col_en_s) begin
                    cols_nxt_s = snap_r[base_s +: C_COL_N];
                end else begin
                    cols_nxt_s = '0;
                end
            end
            default: begin
                row_xen_nxt_s = '1;
                cols_nxt_s    = '0;
            end
        endcase
    end

    // Snapshot and output registers; reset blanks the matrix immediately.
    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            snap_r    <= '0;
            ROW_XEN_o <= '1;
            COLs_o    <= '0;
            FRAME_o   <= 1'b0;
        end else begin
            if (frame_start_s) begin
                snap_r <= LEDs_ON_i;
            end
            ROW_XEN_o <= row_xen_nxt_s;
            COLs_o    <= cols_nxt_s;
            FRAME_o   <= frame_start_s;
        end
    end

endmodule

// File: tb/tb_led_scan_drv.sv
// Scoreboard bench for led_scan_drv: expected output runs are queued by the
// stimulus and consumed by a monitor that compresses the outputs into runs.
module tb_led_scan_drv;

    logic        CK;
    logic        XARST;
    logic [17:0] leds;
    logic [2:0]  row_xen;
    logic [5:0]  cols;
    logic        frame;
`ifdef LED_SCAN_PWM_EN
    logic [3:0]  dim_v;
`endif

    int total_n = 0;
    int bad_n   = 0;

    typedef struct {
        logic [2:0] xen;
        logic [5:0] cols;
        int         len;
    } seg_t;

    seg_t exp_q[$];

    led_scan_drv #(
        .C_ROW_CK_N (64),
        .C_BLANK_N  (16)
    ) dut (
        .CK_i      (CK),
        .XARST_i   (XARST),
        .LEDs_ON_i (leds),
`ifdef LED_SCAN_PWM_EN
        .DIM_i     (dim_v),
`endif
        .ROW_XEN_o (row_xen),
        .COLs_o    (cols),
        .FRAME_o   (frame)
    );

    initial begin
        CK = 1'b0;
        forever #5 CK = ~CK;
    end

    task automatic chk(input string nm, input int act, input int exp);
        total_n++;
        if (act != exp) begin
            bad_n++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Expected DIM level actually applied by the build under test.
    function automatic int eff_dim(input int d);
`ifdef LED_SCAN_PWM_EN
        return d;
`else
        return 15 + 0 * d;
`endif
    endfunction

    task automatic set_dim(input int d);
`ifdef LED_SCAN_PWM_EN
        dim_v = 4'(d);
`else
        if (d < 0) $display("dim ignored");
`endif
    endtask

    // Queue the six output runs of one frame: blank 16, then drive 48 per row.
    task automatic push_frame(input logic [17:0] p, input int d);
        seg_t       s;
        logic [5:0] pc;
        logic [2:0] xen;
        int         on;
        on = (d + 1) * 3;
        for (int r = 0; r < 3; r++) begin
            s.xen = 3'b111; s.cols = 6'h00; s.len = 16;
            exp_q.push_back(s);
            pc = p[r*6 +: 6];
            xen = 3'b111;
            xen[r] = 1'b0;
            if (pc == 6'h00 || on >= 48) begin
                s.xen = xen; s.cols = pc; s.len = 48;
                exp_q.push_back(s);
            end else begin
                s.xen = xen; s.cols = pc; s.len = on;
                exp_q.push_back(s);
                s.xen = xen; s.cols = 6'h00; s.len = 48 - on;
                exp_q.push_back(s);
            end
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge CK);
        #2;
    endtask

    // Monitor: run-length compare, row exclusivity, frame period.
    logic [2:0] run_xen;
    logic [5:0] run_cols;
    int         run_len;
    bit         run_valid = 1'b0;
    int         smp = 0;
    int         last_frame = -1;

    always @(negedge CK) begin
        seg_t e;
        if (!XARST) begin
            run_valid  = 1'b0;
            last_frame = -1;
        end else begin
            smp++;
            chk("one_row_max", ($countones(~row_xen) <= 1) ? 1 : 0, 1);
            chk("cols_off_in_blank", (row_xen == 3'b111 && cols != 6'h00) ? 1 : 0, 0);
            if (run_valid && row_xen == run_xen && cols == run_cols) begin
                run_len++;
            end else begin
                if (run_valid && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("run_row_xen", int'(run_xen), int'(e.xen));
                    chk("run_cols", int'(run_cols), int'(e.cols));
                    chk("run_len", run_len, e.len);
                end
                run_valid = 1'b1;
                run_xen   = row_xen;
                run_cols  = cols;
                run_len   = 1;
            end
            if (frame) begin
                if (last_frame >= 0) chk("frame_period", smp - last_frame, 192);
                last_frame = smp;
            end
        end
    end

    initial begin
        XARST = 1'b0;
        leds  = 18'h3FFFF;
        set_dim(15);
        edges(3);
        chk("rst_row_xen", int'(row_xen), 7);
        chk("rst_cols", int'(cols), 0);
        chk("rst_frame", int'(frame), 0);

        // All on; change to bits 0/5 during row 2 (no effect until next frame).
        push_frame(18'h3FFFF, 15);
        XARST = 1'b1;
        @(posedge CK); #1;
        chk("first_edge_frame", int'(frame), 1);
        #1;
        edges(149);
        leds = 18'h00021;
        push_frame(18'h00021, 15);
        push_frame(18'h00021, 15);

        // Mid-frame change during row 1: shows up from row 0 of the next frame.
        edges(319);
        chk("in_row1_drive", int'(row_xen), 3'b101);
        leds = 18'h2A54C;
        push_frame(18'h2A54C, 15);

        // Asynchronous reset in the middle of row 0 DRIVE.
        edges(331);
        chk("pre_rst_row_xen", int'(row_xen), 3'b110);
        chk("pre_rst_cols", int'(cols), 6'h0C);
        chk("queue_drained_1", exp_q.size(), 0);
        XARST = 1'b0;
        #1;
        chk("async_rst_row_xen", int'(row_xen), 7);
        chk("async_rst_cols", int'(cols), 0);
        chk("async_rst_frame", int'(frame), 0);
        leds = 18'h3F000;
        edges(3);
        push_frame(18'h3F000, 15);
        XARST = 1'b1;
        @(posedge CK); #1;
        chk("restart_frame", int'(frame), 1);
        #1;

        // Dimming levels 0, 7, 15 on an all-on pattern.
        edges(99);
        leds = 18'h3FFFF;
        set_dim(0);
        push_frame(18'h3FFFF, eff_dim(0));
        edges(200);
        set_dim(7);
        push_frame(18'h3FFFF, eff_dim(7));
        edges(200);
        set_dim(15);
        push_frame(18'h3FFFF, eff_dim(15));
        edges(290);
        chk("queue_drained_2", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

endmodule
